// File: rtl/chad_mem_arbiter_if.sv
// Bus bundle between the chad CPU data port, the DMA requester and the shared data RAM.
// The arbiter sits on the slave modport; the CPU/DMA/RAM environment uses master.
interface chad_mem_arbiter_if #(
  parameter int WIDTH  = 18,
  parameter int AWIDTH = 15,
  parameter int LANES  = (WIDTH + 7) / 8
);
  logic              ext_hold;

  logic              cpu_rd;
  logic              cpu_wr;
  logic [AWIDTH-1:0] cpu_addr;
  logic [LANES-1:0]  cpu_lane;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_hold;

  logic              dma_req;
  logic              dma_we;
  logic [AWIDTH-1:0] dma_addr;
  logic [LANES-1:0]  dma_lane;
  logic [WIDTH-1:0]  dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [WIDTH-1:0]  dma_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [LANES-1:0]  ram_lane;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;

  modport slave (
    input  ext_hold,
    input  cpu_rd, cpu_wr, cpu_addr, cpu_lane, cpu_wdata,
    output cpu_rdata, cpu_hold,
    input  dma_req, dma_we, dma_addr, dma_lane, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_en, ram_we, ram_addr, ram_lane, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output ext_hold,
    output cpu_rd, cpu_wr, cpu_addr, cpu_lane, cpu_wdata,
    input  cpu_rdata, cpu_hold,
    output dma_req, dma_we, dma_addr, dma_lane, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_en, ram_we, ram_addr, ram_lane, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/chad_mem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, DMA is forced through after STARVE
// consecutive denials. Read data returns one cycle after grant; CPU read data is latched.
module chad_mem_arbiter #(
  parameter int WIDTH  = 18,
  parameter int AWIDTH = 15,
  parameter int LANES  = (WIDTH + 7) / 8,
  parameter int STARVE = 4
) (
  input  logic                clk,
  input  logic                reset,
  chad_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE);

  logic             cpu_req;
  logic             dma_act;
  logic             starve_hit;
  logic             dma_win;
  logic             cpu_win;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic [1:0]       rsel_q, rsel_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;

  // Requests are ignored entirely while reset is high.
  assign cpu_req    = (bus.cpu_rd | bus.cpu_wr) & ~bus.ext_hold & ~reset;
  assign dma_act    = bus.dma_req & ~reset;
  assign starve_hit = (starve_q >= STARVE_MAX);
  assign dma_win    = dma_act & (~cpu_req | starve_hit);
  assign cpu_win    = cpu_req & ~dma_win;

  always_comb begin
    starve_d = starve_q;
    if (!dma_act || dma_win) begin
      starve_d = '0;
    end else if (cpu_win && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // A simultaneous rd+wr from the CPU is treated as a write, so it records no read owner.
  always_comb begin
    rsel_d      = {dma_win & ~bus.dma_we, cpu_win & ~bus.cpu_wr};
    cpu_rdata_d = cpu_rdata_q;
    if (rsel_q[0]) begin
      cpu_rdata_d = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      rsel_q      <= '0;
      cpu_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      rsel_q      <= rsel_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // RAM port is a pure combinational mux of the winning requester.
  assign bus.ram_en    = cpu_win | dma_win;
  assign bus.ram_we    = dma_win ? bus.dma_we : (cpu_win & bus.cpu_wr);
  assign bus.ram_addr  = dma_win ? bus.dma_addr : bus.cpu_addr;
  assign bus.ram_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.ram_lane  = bus.ram_we ? (dma_win ? bus.dma_lane : bus.cpu_lane) : '1;

  assign bus.cpu_hold  = (bus.ext_hold | (cpu_req & dma_win)) & ~reset;
  assign bus.dma_gnt   = dma_win;

  // Bypass lets the CPU see its word in the data-return cycle; the latch holds it afterwards.
  assign bus.cpu_rdata  = (rsel_q[0] & ~reset) ? bus.ram_rdata : cpu_rdata_q;
  assign bus.dma_rvalid = rsel_q[1] & ~reset;
  assign bus.dma_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_chad_mem_arbiter.sv
// Directed bench for chad_mem_arbiter with a behavioural RAM and read-data scoreboard.
module tb_chad_mem_arbiter;
  localparam int WIDTH  = 18;
  localparam int AWIDTH = 15;
  localparam int LANES  = (WIDTH + 7) / 8;
  localparam int STARVE = 4;

  logic clk;
  logic reset;

  chad_mem_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .LANES(LANES)) bus ();

  chad_mem_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .LANES(LANES), .STARVE(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] exp_cpu_q[$];
  logic [WIDTH-1:0] exp_dma_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural synchronous RAM, 256 words, byte-lane write mask.
  logic [WIDTH-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        for (int b = 0; b < WIDTH; b++)
          if (bus.ram_lane[b/8]) mem[bus.ram_addr[7:0]][b] <= bus.ram_wdata[b];
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr[7:0]];
      end
    end
  end

  // Monitor: pops the expected read word whenever the DUT returns one.
  logic cpu_pend = 1'b0;
  always @(negedge clk) begin
    if (bus.dma_rvalid === 1'b1) begin
      if (exp_dma_q.size() == 0) check("dma_rvalid_unexpected", 32'(bus.dma_rdata), 32'h0);
      else check("dma_rdata", 32'(bus.dma_rdata), 32'(exp_dma_q.pop_front()));
    end
    if (cpu_pend && !reset) begin
      if (exp_cpu_q.size() == 0) check("cpu_read_unexpected", 32'(bus.cpu_rdata), 32'h0);
      else check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_q.pop_front()));
    end
    cpu_pend = (bus.ram_en === 1'b1) && (bus.ram_we === 1'b0) && (bus.dma_gnt === 1'b0) && !reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ext_hold  = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_lane  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_lane  = '0;
    bus.dma_wdata = '0;
  endtask

  logic [7:0] req_pat = 8'b1111_1011;  // bit i = dma_req in cycle i (cycle 2 drops)

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 18'h2A5A5;
    mem[8'h11] = 18'h00111;
    mem[8'h12] = 18'h12345;
    mem[8'h30] = 18'h15555;
    mem[8'h31] = 18'h2AAAA;
    mem[8'h41] = 18'h0BEEF;
    bus.ram_rdata = '0;
    idle();

    // Reset with requests present: everything gated.
    reset = 1'b1;
    bus.cpu_rd = 1'b1; bus.dma_req = 1'b1; bus.ext_hold = 1'b1;
    step(); step();
    #2;
    check("rst_ram_en",   32'(bus.ram_en),   32'h0);
    check("rst_dma_gnt",  32'(bus.dma_gnt),  32'h0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'h0);
    check("rst_ram_we",   32'(bus.ram_we),   32'h0);
    step();
    reset = 1'b0;
    idle();
    #2;
    check("rst_cpu_rdata", 32'(bus.cpu_rdata),  32'h0);
    check("rst_rvalid",    32'(bus.dma_rvalid), 32'h0);
    step();

    // 1: lone CPU read.
    bus.cpu_rd = 1'b1; bus.cpu_addr = 15'h10;
    #2;
    check("t1_ram_en",   32'(bus.ram_en),   32'h1);
    check("t1_cpu_hold", 32'(bus.cpu_hold), 32'h0);
    check("t1_ram_addr", 32'(bus.ram_addr), 32'h10);
    check("t1_ram_lane", 32'(bus.ram_lane), 32'h7);
    exp_cpu_q.push_back(18'h2A5A5);
    step();
    idle();
    #2;
    check("t1_ram_en_off", 32'(bus.ram_en), 32'h0);
    step();
    #2;
    check("t1_cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h2A5A5);
    step();

    // 2: CPU reading continuously against a held DMA read.
    bus.cpu_rd = 1'b1; bus.cpu_addr = 15'h11;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 15'h12;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.dma_req = 1'b0;
      #2;
      check($sformatf("t2_gnt_%0d", i),  32'(bus.dma_gnt),  (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("t2_hold_%0d", i), 32'(bus.cpu_hold), (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("t2_addr_%0d", i), 32'(bus.ram_addr), (i == 4) ? 32'h12 : 32'h11);
      if (i == 4) exp_dma_q.push_back(18'h12345);
      else exp_cpu_q.push_back(18'h00111);
      step();
    end

    // Dropped request clears the starvation count.
    for (int i = 0; i < 8; i++) begin
      bus.dma_req = req_pat[i];
      #2;
      check($sformatf("t2b_gnt_%0d", i), 32'(bus.dma_gnt), (i == 7) ? 32'h1 : 32'h0);
      if (i == 7) exp_dma_q.push_back(18'h12345);
      else exp_cpu_q.push_back(18'h00111);
      step();
    end
    idle();
    step();

    // 3: DMA byte-lane write with CPU idle, then read it back.
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 15'h20;
    bus.dma_lane = 3'b001; bus.dma_wdata = 18'h3FFFF;
    #2;
    check("t3_gnt",   32'(bus.dma_gnt),   32'h1);
    check("t3_we",    32'(bus.ram_we),    32'h1);
    check("t3_lane",  32'(bus.ram_lane),  32'h1);
    check("t3_wdata", 32'(bus.ram_wdata), 32'h3FFFF);
    check("t3_hold",  32'(bus.cpu_hold),  32'h0);
    step();
    bus.dma_we = 1'b0; bus.dma_lane = '0; bus.dma_wdata = '0;
    #2;
    check("t3_rd_gnt", 32'(bus.dma_gnt), 32'h1);
    exp_dma_q.push_back(18'h000FF);
    step();
    idle();
    step();

    // 4: CPU read followed by a DMA read; CPU word must survive.
    bus.cpu_rd = 1'b1; bus.cpu_addr = 15'h30;
    exp_cpu_q.push_back(18'h15555);
    step();
    idle();
    bus.dma_req = 1'b1; bus.dma_addr = 15'h31;
    #2;
    check("t4_gnt", 32'(bus.dma_gnt), 32'h1);
    exp_dma_q.push_back(18'h2AAAA);
    step();
    idle();
    #2;
    check("t4_cpu_keep1", 32'(bus.cpu_rdata), 32'h15555);
    step();
    #2;
    check("t4_cpu_keep2", 32'(bus.cpu_rdata), 32'h15555);
    step();

    // 5: ext_hold with pending CPU write and DMA read.
    bus.ext_hold = 1'b1;
    bus.cpu_wr = 1'b1; bus.cpu_addr = 15'h40; bus.cpu_lane = 3'b111; bus.cpu_wdata = 18'h11111;
    bus.dma_req = 1'b1; bus.dma_addr = 15'h41;
    #2;
    check("t5_gnt",   32'(bus.dma_gnt),  32'h1);
    check("t5_hold",  32'(bus.cpu_hold), 32'h1);
    check("t5_we",    32'(bus.ram_we),   32'h0);
    check("t5_addr",  32'(bus.ram_addr), 32'h41);
    exp_dma_q.push_back(18'h0BEEF);
    step();
    bus.dma_req = 1'b0;
    #2;
    check("t5_starve", 32'(dut.starve_q), 32'h0);
    check("t5_no_en",  32'(bus.ram_en),   32'h0);
    check("t5_hold2",  32'(bus.cpu_hold), 32'h1);
    step();
    #2;
    check("t5_mem_untouched", 32'(mem[8'h40]), 32'h0);
    idle();
    step();

    // 6: reset pulsed in the data-return cycle of a DMA read.
    bus.dma_req = 1'b1; bus.dma_addr = 15'h12;
    #2;
    check("t6_gnt", 32'(bus.dma_gnt), 32'h1);
    step();
    reset = 1'b1;
    bus.dma_req = 1'b1; bus.cpu_rd = 1'b1; bus.ext_hold = 1'b1;
    #2;
    check("t6_rvalid_rst", 32'(bus.dma_rvalid), 32'h0);
    check("t6_en_rst",     32'(bus.ram_en),     32'h0);
    check("t6_gnt_rst",    32'(bus.dma_gnt),    32'h0);
    check("t6_hold_rst",   32'(bus.cpu_hold),   32'h0);
    step();
    reset = 1'b0;
    idle();
    #2;
    check("t6_rvalid_after", 32'(bus.dma_rvalid), 32'h0);
    check("t6_cpu_rdata",    32'(bus.cpu_rdata),  32'h0);
    check("t6_starve",       32'(dut.starve_q),   32'h0);
    check("t6_rsel",         32'(dut.rsel_q),     32'h0);
    step(); step();

    check("cpu_queue_drained", 32'(exp_cpu_q.size()), 32'h0);
    check("dma_queue_drained", 32'(exp_dma_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
